// File: rtl/led_seq_gen_if.sv
// ============================================================================
// Module   : led_seq_gen_if
// Purpose  : Control/status bundle for the LED pattern sequencer.
//            master = controller (drives run/mode/rate, reads LEDs and strobes)
//            slave  = led_seq_gen
// Signals  : en     run (1) / pause (0)
//            mode   0 walk-up, 1 walk-down, 2 bounce, 3 binary count
//            div    tick period minus one, in clk cycles
//            bright PWM duty in 1/16 steps (only with LED_SEQ_PWM_EN)
//            led    pattern output
//            step   one-cycle pulse with each new led value
//            wrap   one-cycle pulse when the pattern returns to its start
// Options  : LED_SEQ_PWM_EN adds the bright signal
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_seq_gen_if #(
  parameter int N_LEDS = 5,
  parameter int DIV_W  = 32
);
  logic              en;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  div;
`ifdef LED_SEQ_PWM_EN
  logic [3:0]        bright;
`endif
  logic [N_LEDS-1:0] led;
  logic              step;
  logic              wrap;

`ifdef LED_SEQ_PWM_EN
  modport master (output en, mode, div, bright, input led, step, wrap);
  modport slave  (input en, mode, div, bright, output led, step, wrap);
`else
  modport master (output en, mode, div, input led, step, wrap);
  modport slave  (input en, mode, div, output led, step, wrap);
`endif
endinterface

`default_nettype wire

// File: rtl/led_seq_gen.sv
// ============================================================================
// Module   : led_seq_gen
// Purpose  : Parametrised LED pattern sequencer (walk-up, walk-down, bounce,
//            binary count) advanced by a clock-enable tick from a runtime
//            programmable divider. No generated clocks.
// Ports    : nrst  asynchronous active-low reset
//            clk   system clock
//            bus   led_seq_gen_if.slave (en, mode, div, [bright], led,
//                  step, wrap)
// Params   : N_LEDS (2..32) number of LEDs; DIV_W divider width. Both must
//            match the parameters of the connected interface instance.
// Options  : LED_SEQ_PWM_EN - adds bright input and registered PWM gating
//            of led (led then lags the pattern by one cycle).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_seq_gen #(
  parameter int N_LEDS = 5,
  parameter int DIV_W  = 32
) (
  input wire logic     nrst,
  input wire logic     clk,
  led_seq_gen_if.slave bus
);

  localparam logic [1:0] MODE_WALK_UP   = 2'd0;
  localparam logic [1:0] MODE_WALK_DOWN = 2'd1;
  localparam logic [1:0] MODE_BOUNCE    = 2'd2;
  localparam logic [1:0] MODE_COUNT     = 2'd3;

  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  localparam logic [N_LEDS-1:0] PAT_LSB = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] PAT_MSB = {1'b1, {(N_LEDS-1){1'b0}}};

  logic [DIV_W-1:0]  count_q,   count_d;
  logic [N_LEDS-1:0] pattern_q, pattern_d;
  logic [0:0]        dir_q,     dir_d;
  logic [1:0]        mode_q,    mode_d;
  logic              blank_q,   blank_d;
  logic              step_q,    step_d;
  logic              wrap_q,    wrap_d;
  logic              tick_w;

  // div is compared live with >= so lowering it below the running count
  // produces a tick on the very next enabled cycle.
  assign tick_w = bus.en && (count_q >= bus.div);

  always_comb begin
    count_d   = count_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    blank_d   = blank_q;
    step_d    = 1'b0;
    wrap_d    = 1'b0;

    if (bus.en) begin
      count_d = tick_w ? '0 : count_q + 1'b1;
    end

    if (tick_w) begin
      step_d = 1'b1;
      mode_d = bus.mode;
      if (blank_q || (bus.mode != mode_q)) begin
        // Start-value load: never a wrap.
        blank_d = 1'b0;
        case (bus.mode)
          MODE_WALK_DOWN: pattern_d = PAT_MSB;
          MODE_BOUNCE: begin
            pattern_d = PAT_LSB;
            dir_d     = DIR_UP;
          end
          default:        pattern_d = PAT_LSB;
        endcase
      end else begin
        case (bus.mode)
          MODE_WALK_UP: begin
            pattern_d = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
            wrap_d    = (pattern_d == PAT_LSB);
          end
          MODE_WALK_DOWN: begin
            pattern_d = {pattern_q[0], pattern_q[N_LEDS-1:1]};
            wrap_d    = (pattern_d == PAT_MSB);
          end
          MODE_BOUNCE: begin
            // Direction flips as soon as an end LED is reached, so each
            // end LED is shown for a single tick per pass.
            if (dir_q == DIR_UP) begin
              pattern_d = pattern_q << 1;
              if (pattern_d[N_LEDS-1]) dir_d = DIR_DOWN;
            end else begin
              pattern_d = pattern_q >> 1;
              if (pattern_d[0]) dir_d = DIR_UP;
            end
            wrap_d = (pattern_d == PAT_LSB);
          end
          MODE_COUNT: begin
            pattern_d = pattern_q + 1'b1;
            wrap_d    = (pattern_d == '0);
          end
          default: pattern_d = pattern_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q   <= '0;
      pattern_q <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= MODE_WALK_UP;
      blank_q   <= 1'b1;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      blank_q   <= blank_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.step = step_q;
  assign bus.wrap = wrap_q;

`ifdef LED_SEQ_PWM_EN
  logic [3:0]        pwm_cnt_q;
  logic [N_LEDS-1:0] led_q;

  // Free-running PWM; the gate is registered so led trails the pattern by
  // one cycle while step/wrap stay aligned to the pattern register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pwm_cnt_q <= 4'd0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      led_q     <= pattern_q & {N_LEDS{pwm_cnt_q < bus.bright}};
    end
  end

  assign bus.led = led_q;
`else
  assign bus.led = pattern_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_seq_gen.sv
// ============================================================================
// Module   : tb_led_seq_gen
// Purpose  : Self-checking bench for led_seq_gen. A position/value model
//            predicts led/step/wrap every cycle; directed phases pin the
//            model with literal expectations, then a randomized phase runs.
// Options  : LED_SEQ_PWM_EN (bench follows the RTL build option)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_seq_gen;

  localparam int N_LEDS = 5;
  localparam int DIV_W  = 32;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_seq_gen_if #(.N_LEDS(N_LEDS), .DIV_W(DIV_W)) bus ();

  led_seq_gen #(.N_LEDS(N_LEDS), .DIV_W(DIV_W)) dut (
    .nrst (nrst),
    .clk  (clk),
    .bus  (bus.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: LED position index / counter value, not bit vectors.
  // --------------------------------------------------------------------------
  longint m_cnt;
  bit     m_blank;
  int     m_mode;    // mode seen at the last tick
  int     m_pos;     // lit LED index for one-hot modes
  int     m_val;     // counter value for binary mode
  int     m_bdir;    // +1 / -1 for bounce
  bit     e_step, e_wrap;
  int     m_pwm, m_gated;

  function automatic int model_pattern();
    if (m_blank) return 0;
    if (m_mode == 3) return m_val;
    return 1 << m_pos;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_blank = 1; m_mode = 0; m_pos = 0; m_val = 0; m_bdir = 1;
    e_step = 0; e_wrap = 0; m_pwm = 0; m_gated = 0;
  endtask

  task automatic model_next();
    bit tick;
    int md;
    md   = int'(bus.mode);
    tick = 0;
`ifdef LED_SEQ_PWM_EN
    m_gated = (m_pwm < int'(bus.bright)) ? model_pattern() : 0;
    m_pwm   = (m_pwm + 1) % 16;
`endif
    if (bus.en) begin
      tick  = (m_cnt >= longint'(bus.div));
      m_cnt = tick ? 0 : m_cnt + 1;
    end
    e_step = tick;
    e_wrap = 0;
    if (tick) begin
      if (m_blank || md != m_mode) begin
        m_blank = 0;
        m_pos   = (md == 1) ? N_LEDS - 1 : 0;
        m_val   = 1;
        m_bdir  = 1;
      end else begin
        case (md)
          0: begin m_pos = (m_pos + 1) % N_LEDS; e_wrap = (m_pos == 0); end
          1: begin m_pos = (m_pos + N_LEDS - 1) % N_LEDS; e_wrap = (m_pos == N_LEDS - 1); end
          2: begin
            m_pos = m_pos + m_bdir;
            if (m_pos == N_LEDS - 1) m_bdir = -1;
            if (m_pos == 0)          m_bdir = 1;
            e_wrap = (m_pos == 0);
          end
          default: begin m_val = (m_val + 1) % (1 << N_LEDS); e_wrap = (m_val == 0); end
        endcase
      end
      m_mode = md;
    end
  endtask

  // Compare process: outputs checked on every falling edge, then the model
  // is advanced with the inputs that the next rising edge will sample.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!nrst) begin
        model_reset();
        chk("rst_led",  64'(bus.led),  64'd0);
        chk("rst_step", 64'(bus.step), 64'd0);
        chk("rst_wrap", 64'(bus.wrap), 64'd0);
      end else begin
`ifdef LED_SEQ_PWM_EN
        chk("model_led", 64'(bus.led), 64'(m_gated));
`else
        chk("model_led", 64'(bus.led), 64'(model_pattern()));
`endif
        chk("model_step", 64'(bus.step), 64'(e_step));
        chk("model_wrap", 64'(bus.wrap), 64'(e_wrap));
        model_next();
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers: wait n rising edges, expecting a step on the last one.
  // --------------------------------------------------------------------------
  task automatic tick_wait(input string name, input int n, input int exp_led, input bit exp_wrap);
    if (n > 1) begin
      repeat (n - 1) @(posedge clk);
      #2 chk({name, "_nostep"}, 64'(bus.step), 64'd0);
    end
    @(posedge clk);
    #2;
`ifndef LED_SEQ_PWM_EN
    chk({name, "_led"}, 64'(bus.led), 64'(exp_led));
`endif
    chk({name, "_step"}, 64'(bus.step), 64'd1);
    chk({name, "_wrap"}, 64'(bus.wrap), 64'(exp_wrap));
  endtask

  int walk_up[6]   = '{1, 2, 4, 8, 16, 1};
  int walk_dn[6]   = '{16, 8, 4, 2, 1, 16};
  int bounce[10]   = '{1, 2, 4, 8, 16, 8, 4, 2, 1, 2};

  initial begin
    bus.en   = 1'b1;
    bus.mode = 2'd0;
    bus.div  = 32'd3;
`ifdef LED_SEQ_PWM_EN
    bus.bright = 4'd15;
`endif
    repeat (2) @(posedge clk);
    #2 nrst = 1'b1;
    chk("post_rst_led", 64'(bus.led), 64'd0);

    // Walk-up at div=3: first update 4 edges after release, wrap on 2nd 00001.
    for (int i = 0; i < 6; i++) tick_wait("walk_up", 4, walk_up[i], i == 5);
    tick_wait("walk_up", 4, 2, 1'b0);
    tick_wait("walk_up", 4, 4, 1'b0);

    // Mode change at 00100: walk-down start value, no wrap.
    bus.mode = 2'd1;
    for (int i = 0; i < 6; i++) tick_wait("walk_dn", 4, walk_dn[i], i == 5);

    // Pause mid-count with div=9.
    bus.mode = 2'd0;
    bus.div  = 32'd9;
    tick_wait("pause_load", 10, 1, 1'b0);
    repeat (3) @(posedge clk);
    #2 bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2 chk("pause_step", 64'(bus.step), 64'd0);
`ifndef LED_SEQ_PWM_EN
      chk("pause_led", 64'(bus.led), 64'd1);
`endif
    end
    bus.en = 1'b1;
    tick_wait("resume", 7, 2, 1'b0);

    // Bounce at div=0: step continuously high.
    bus.mode = 2'd2;
    bus.div  = 32'd0;
    for (int i = 0; i < 10; i++) tick_wait("bounce", 1, bounce[i], i == 8);

    // Binary count: 1..31, 0 (wrap), 1.
    bus.mode = 2'd3;
    for (int i = 1; i <= 33; i++) tick_wait("count", 1, i % 32, i == 32);

    // Asynchronous reset mid-sequence, then restart from blank.
    nrst = 1'b0;
    #1;
    chk("async_rst_led",  64'(bus.led),  64'd0);
    chk("async_rst_step", 64'(bus.step), 64'd0);
    chk("async_rst_wrap", 64'(bus.wrap), 64'd0);
    @(posedge clk);
    #2 nrst = 1'b1;
    bus.mode = 2'd0;
    tick_wait("restart", 1, 1, 1'b0);

`ifdef LED_SEQ_PWM_EN
    begin
      int highs;
      bus.en     = 1'b0;
      bus.bright = 4'd4;
      repeat (2) @(posedge clk);
      highs = 0;
      for (int i = 0; i < 16; i++) begin
        @(posedge clk);
        #2 if (bus.led[0]) highs++;
      end
      chk("pwm_duty4", 64'(highs), 64'd4);
      bus.bright = 4'd0;
      bus.en     = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 16; i++) begin
        @(posedge clk);
        #2 chk("pwm_dark_led", 64'(bus.led), 64'd0);
        chk("pwm_dark_step", 64'(bus.step), 64'd1);
      end
    end
`endif

    // Randomized phase: the compare process does all checking here.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      if (!nrst) nrst = 1'b1;
      else if ($urandom_range(0, 499) == 0) nrst = 1'b0;
      bus.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) bus.div  = 32'($urandom_range(0, 4));
`ifdef LED_SEQ_PWM_EN
      if ($urandom_range(0, 49) == 0) bus.bright = 4'($urandom_range(0, 15));
`endif
    end

    repeat (2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
